// File: rtl/freq_sweep_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : freq_sweep_scheduler
//  Description : Steps the AD9911 frequency-word offset from a start value by
//                a fixed two's-complement step over N points. Each point runs
//                the UPDATE/UPDATED handshake with the frequency updater, then
//                holds for a programmable dwell. Optional continuous looping.
//  Ports       :
//    CLOCK_10M   in   system clock, rising edge
//    RESET       in   synchronous active-high reset
//    START       in   one-cycle pulse, begins a sweep (needs INITIED=1)
//    ABORT       in   one-cycle pulse, stops the sweep
//    CONTINUOUS  in   restart at point 0 after the last point
//    SWEEP_START in   frequency word of point 0
//    SWEEP_STEP  in   per-point increment (two's complement)
//    SWEEP_COUNT in   points per pass
//    DWELL       in   hold cycles after each completed write
//    INITIED     in   updater initialisation complete
//    UPDATED     in   updater write-complete flag
//    FREQW       out  frequency word to the updater
//    UPDATE      out  update request to the updater
//    BUSY        out  high while not idle
//    POINT_IDX   out  index of the current point
//    POINT_STB   out  pulse when a point's write completes
//    DONE        out  pulse at the end of each pass
//    ERROR       out  sticky timeout / updater-reset flag
//  Revision    : 1.0  initial release
// ============================================================================
module freq_sweep_scheduler #(
  parameter int FW_WIDTH    = 32,
  parameter int CNT_WIDTH   = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 CLOCK_10M,
  input  logic                 RESET,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic                 CONTINUOUS,
  input  logic [FW_WIDTH-1:0]  SWEEP_START,
  input  logic [FW_WIDTH-1:0]  SWEEP_STEP,
  input  logic [CNT_WIDTH-1:0] SWEEP_COUNT,
  input  logic [CNT_WIDTH-1:0] DWELL,
  input  logic                 INITIED,
  input  logic                 UPDATED,
  output logic [FW_WIDTH-1:0]  FREQW,
  output logic                 UPDATE,
  output logic                 BUSY,
  output logic [CNT_WIDTH-1:0] POINT_IDX,
  output logic                 POINT_STB,
  output logic                 DONE,
  output logic                 ERROR
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  // Counter value on the last permitted ISSUE/WAIT_DONE cycle
  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_DWELL     = 3'd3,
    S_NEXT      = 3'd4,
    S_DRAIN     = 3'd5
  } state_t;

  state_t               r_state,     w_state_nxt;
  logic [FW_WIDTH-1:0]  r_freqw,     w_freqw_nxt;
  logic [FW_WIDTH-1:0]  r_start_lat, w_start_lat_nxt;
  logic [FW_WIDTH-1:0]  r_step,      w_step_nxt;
  logic [CNT_WIDTH-1:0] r_count,     w_count_nxt;
  logic [CNT_WIDTH-1:0] r_dwell,     w_dwell_nxt;
  logic                 r_cont,      w_cont_nxt;
  logic [CNT_WIDTH-1:0] r_point_idx, w_point_idx_nxt;
  logic [CNT_WIDTH-1:0] r_dwell_cnt, w_dwell_cnt_nxt;
  logic [TO_W-1:0]      r_to_cnt,    w_to_cnt_nxt;
  logic                 r_update,    w_update_nxt;
  logic                 r_point_stb, w_point_stb_nxt;
  logic                 r_done,      w_done_nxt;
  logic                 r_error,     w_error_nxt;
  logic                 r_busy;
  logic                 w_timeout;
  logic                 w_last_point;

  assign w_timeout    = (r_to_cnt == C_TO_LAST);
  assign w_last_point = (r_point_idx == r_count - CNT_WIDTH'(1));

  always_ff @(posedge CLOCK_10M) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_freqw     <= '0;
      r_start_lat <= '0;
      r_step      <= '0;
      r_count     <= '0;
      r_dwell     <= '0;
      r_cont      <= 1'b0;
      r_point_idx <= '0;
      r_dwell_cnt <= '0;
      r_to_cnt    <= '0;
      r_update    <= 1'b0;
      r_point_stb <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_freqw     <= w_freqw_nxt;
      r_start_lat <= w_start_lat_nxt;
      r_step      <= w_step_nxt;
      r_count     <= w_count_nxt;
      r_dwell     <= w_dwell_nxt;
      r_cont      <= w_cont_nxt;
      r_point_idx <= w_point_idx_nxt;
      r_dwell_cnt <= w_dwell_cnt_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_update    <= w_update_nxt;
      r_point_stb <= w_point_stb_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
      // BUSY is registered from the next state so it tracks state != IDLE
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_freqw_nxt     = r_freqw;
    w_start_lat_nxt = r_start_lat;
    w_step_nxt      = r_step;
    w_count_nxt     = r_count;
    w_dwell_nxt     = r_dwell;
    w_cont_nxt      = r_cont;
    w_point_idx_nxt = r_point_idx;
    w_dwell_cnt_nxt = r_dwell_cnt;
    w_to_cnt_nxt    = '0;
    w_update_nxt    = r_update;
    w_point_stb_nxt = 1'b0;
    w_done_nxt      = 1'b0;
    w_error_nxt     = r_error;

    if (r_state == S_IDLE) begin
      w_update_nxt = 1'b0;
      // START beats a same-cycle ABORT here since ABORT is a no-op in IDLE
      if (START && INITIED) begin
        w_start_lat_nxt = SWEEP_START;
        w_step_nxt      = SWEEP_STEP;
        w_count_nxt     = SWEEP_COUNT;
        w_dwell_nxt     = DWELL;
        w_cont_nxt      = CONTINUOUS;
        w_error_nxt     = 1'b0;
        w_point_idx_nxt = '0;
        w_freqw_nxt     = SWEEP_START;
        if (SWEEP_COUNT == '0) begin
          w_done_nxt = 1'b1;
        end else begin
          w_state_nxt  = S_ISSUE;
          w_update_nxt = 1'b1;
        end
      end
    end else if (!INITIED) begin
      // Updater has reset itself; any handshake in progress is void
      w_update_nxt = 1'b0;
      w_error_nxt  = 1'b1;
      w_state_nxt  = S_IDLE;
    end else if (ABORT) begin
      w_update_nxt = 1'b0;
      // A write already acknowledged must finish before a new sweep may start
      w_state_nxt  = (r_state == S_WAIT_DONE) ? S_DRAIN : S_IDLE;
    end else begin
      case (r_state)
        S_ISSUE: begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
          // UPDATED low is the acknowledge; a stale high from the last point
          // is therefore never taken as completion of this one
          if (!UPDATED) begin
            w_state_nxt = S_WAIT_DONE;
          end else if (w_timeout) begin
            w_error_nxt  = 1'b1;
            w_update_nxt = 1'b0;
            w_state_nxt  = S_IDLE;
          end
        end
        S_WAIT_DONE: begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
          if (UPDATED) begin
            w_update_nxt    = 1'b0;
            w_point_stb_nxt = 1'b1;
            w_to_cnt_nxt    = '0;
            w_dwell_cnt_nxt = r_dwell;
            w_state_nxt     = (r_dwell == '0) ? S_NEXT : S_DWELL;
          end else if (w_timeout) begin
            w_error_nxt  = 1'b1;
            w_update_nxt = 1'b0;
            w_state_nxt  = S_IDLE;
          end
        end
        S_DWELL: begin
          // Loaded with DWELL on entry, so exactly DWELL cycles are spent here
          if (r_dwell_cnt <= CNT_WIDTH'(1)) begin
            w_state_nxt = S_NEXT;
          end else begin
            w_dwell_cnt_nxt = r_dwell_cnt - CNT_WIDTH'(1);
          end
        end
        S_NEXT: begin
          if (!w_last_point) begin
            w_point_idx_nxt = r_point_idx + CNT_WIDTH'(1);
            w_freqw_nxt     = r_freqw + r_step;
            w_update_nxt    = 1'b1;
            w_state_nxt     = S_ISSUE;
          end else begin
            w_done_nxt = 1'b1;
            if (r_cont) begin
              w_point_idx_nxt = '0;
              w_freqw_nxt     = r_start_lat;
              w_update_nxt    = 1'b1;
              w_state_nxt     = S_ISSUE;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (UPDATED) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_update_nxt = 1'b0;
          w_state_nxt  = S_IDLE;
        end
      endcase
    end
  end

  assign FREQW     = r_freqw;
  assign UPDATE    = r_update;
  assign BUSY      = r_busy;
  assign POINT_IDX = r_point_idx;
  assign POINT_STB = r_point_stb;
  assign DONE      = r_done;
  assign ERROR     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_freq_sweep_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_freq_sweep_scheduler
//  Description : Scoreboard bench for freq_sweep_scheduler with a behavioural
//                frequency-updater model and randomized sweeps.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_freq_sweep_scheduler;

  localparam int FW = 32;
  localparam int CW = 16;
  localparam int TO = 4096;

  logic          CLOCK_10M = 1'b0;
  logic          RESET = 1'b1;
  logic          START = 1'b0;
  logic          ABORT = 1'b0;
  logic          CONTINUOUS = 1'b0;
  logic [FW-1:0] SWEEP_START = '0;
  logic [FW-1:0] SWEEP_STEP = '0;
  logic [CW-1:0] SWEEP_COUNT = '0;
  logic [CW-1:0] DWELL = '0;
  logic          INITIED = 1'b0;
  logic          UPDATED;
  logic [FW-1:0] FREQW;
  logic          UPDATE;
  logic          BUSY;
  logic [CW-1:0] POINT_IDX;
  logic          POINT_STB;
  logic          DONE;
  logic          ERROR;

  freq_sweep_scheduler #(.FW_WIDTH(FW), .CNT_WIDTH(CW), .TIMEOUT_CYC(TO)) u_dut (
    .CLOCK_10M  (CLOCK_10M),
    .RESET      (RESET),
    .START      (START),
    .ABORT      (ABORT),
    .CONTINUOUS (CONTINUOUS),
    .SWEEP_START(SWEEP_START),
    .SWEEP_STEP (SWEEP_STEP),
    .SWEEP_COUNT(SWEEP_COUNT),
    .DWELL      (DWELL),
    .INITIED    (INITIED),
    .UPDATED    (UPDATED),
    .FREQW      (FREQW),
    .UPDATE     (UPDATE),
    .BUSY       (BUSY),
    .POINT_IDX  (POINT_IDX),
    .POINT_STB  (POINT_STB),
    .DONE       (DONE),
    .ERROR      (ERROR)
  );

  always #50 CLOCK_10M = ~CLOCK_10M;

  int cyc = 0;
  always @(posedge CLOCK_10M) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int          kind;   // 0 = point completes, 1 = end of pass
    int          idx;
    logic [31:0] fw;
  } ev_t;
  ev_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference: point i of a pass carries start + i*step (mod 2^32)
  task automatic push_sweep(input logic [31:0] s, input logic [31:0] st, input int cnt, input int passes);
    ev_t e;
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < cnt; i++) begin
        e.kind = 0; e.idx = i; e.fw = s + st * 32'(i);
        exp_q.push_back(e);
      end
      e.kind = 1; e.idx = 0; e.fw = '0;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_ev(input int kind, input int idx, input logic [31:0] fw);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got kind=%0d idx=%0d freqw=%0h, required none", kind, idx, fw);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == 0 && (e.idx != idx || e.fw !== fw))) begin
        miscompares++;
        $display("FAIL event: got kind=%0d idx=%0d freqw=%0h, required kind=%0d idx=%0d freqw=%0h",
                 kind, idx, fw, e.kind, e.idx, e.fw);
      end
    end
  endtask

  // ---------------- monitor ----------------
  int   stb_cnt = 0, done_cnt = 0, upd_rises = 0;
  int   cur_dwell = 0;
  int   stb_cyc = 0;
  bit   stb_pending = 0;
  logic upd_prev = 1'b0;

  always @(negedge CLOCK_10M) begin
    if (!RESET) begin
      if (POINT_STB) begin
        stb_cnt++;
        stb_pending = 1;
        stb_cyc = cyc;
        check_ev(0, int'(POINT_IDX), FREQW);
      end
      if (DONE) begin
        done_cnt++;
        check_ev(1, 0, '0);
      end
      if (UPDATE && !upd_prev) begin
        upd_rises++;
        if (stb_pending) begin
          // After a point: DWELL hold cycles plus one stepping cycle
          vectors++;
          if ((cyc - stb_cyc) < cur_dwell + 1 || (cyc - stb_cyc) > cur_dwell + 2) begin
            miscompares++;
            $display("FAIL dwell_gap: got %0d cycles, required %0d..%0d", cyc - stb_cyc, cur_dwell + 1, cur_dwell + 2);
          end
          stb_pending = 0;
        end
      end
      if (!BUSY) stb_pending = 0;
    end else begin
      stb_pending = 0;
    end
    upd_prev = UPDATE;
  end

  // ---------------- updater model ----------------
  int u_st = 0;
  int u_cnt = 0;
  bit hang = 0;
  bit rand_lat = 0;

  initial begin
    UPDATED = 1'b0;
    forever begin
      @(negedge CLOCK_10M);
      if (!INITIED) begin
        UPDATED = 1'b0;
        u_st = 0;
      end else begin
        case (u_st)
          0: if (UPDATE && !hang) begin
               UPDATED = 1'b0;
               u_cnt = rand_lat ? int'($urandom_range(2, 12)) : 20;
               u_st = 1;
             end
          1: begin
               u_cnt--;
               if (u_cnt == 0) begin UPDATED = 1'b1; u_st = 2; u_cnt = 2; end
             end
          default: begin
               u_cnt--;
               if (u_cnt == 0) u_st = 0;
             end
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLOCK_10M);
    #1;
  endtask

  task automatic start_sweep(input logic [31:0] s, input logic [31:0] st, input int cnt, input int dw, input bit cont);
    SWEEP_START = s; SWEEP_STEP = st; SWEEP_COUNT = CW'(cnt); DWELL = CW'(dw); CONTINUOUS = cont;
    cur_dwell = dw;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (BUSY && n < budget) begin tick(); n++; end
    chk(name, 64'(BUSY), 64'd0);
  endtask

  task automatic wait_acked(input string name);
    int n = 0;
    while (u_st != 1 && n < 100) begin tick(); n++; end
    chk(name, 64'(u_st), 64'd1);
  endtask

  int r0, d0, s0, t0, n;

  initial begin
    #200000000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_freqw", 64'(FREQW), 0);
    chk("rst_update", 64'(UPDATE), 0);
    chk("rst_busy", 64'(BUSY), 0);
    chk("rst_idx", 64'(POINT_IDX), 0);
    chk("rst_stb", 64'(POINT_STB), 0);
    chk("rst_done", 64'(DONE), 0);
    chk("rst_error", 64'(ERROR), 0);
    RESET = 1'b0;
    tick(2);

    // START with INITIED low is ignored
    start_sweep(32'd1000, 32'd100, 3, 5, 0);
    chk("start_no_init_busy", 64'(BUSY), 0);
    tick(3);
    chk("start_no_init_busy2", 64'(BUSY), 0);
    INITIED = 1'b1;
    tick(3);

    // Basic sweep
    d0 = done_cnt;
    push_sweep(32'd1000, 32'd100, 3, 1);
    start_sweep(32'd1000, 32'd100, 3, 5, 0);
    chk("basic_busy", 64'(BUSY), 1);
    wait_idle(500, "basic_idle");
    chk("basic_update_low", 64'(UPDATE), 0);
    tick(3);
    chk("basic_done_count", 64'(done_cnt - d0), 1);
    chk("basic_queue_empty", 64'(exp_q.size()), 0);

    // Negative step with wrap
    push_sweep(32'h10, 32'hFFFF_FFF0, 3, 1);
    start_sweep(32'h10, 32'hFFFF_FFF0, 3, 2, 0);
    wait_idle(500, "neg_idle");
    tick(3);
    chk("neg_queue_empty", 64'(exp_q.size()), 0);

    // Continuous: three passes, then abort during the dwell of the next point
    d0 = done_cnt; s0 = stb_cnt;
    push_sweep(32'd1000, 32'd100, 2, 3);
    exp_q.push_back('{kind: 0, idx: 0, fw: 32'd1000});
    start_sweep(32'd1000, 32'd100, 2, 5, 1);
    n = 0;
    while (stb_cnt < s0 + 7 && n < 2000) begin tick(); n++; end
    chk("cont_points_seen", 64'(stb_cnt - s0), 7);
    chk("cont_done_count", 64'(done_cnt - d0), 3);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    CONTINUOUS = 1'b0;
    chk("cont_abort_busy", 64'(BUSY), 0);
    chk("cont_abort_update", 64'(UPDATE), 0);
    r0 = upd_rises;
    tick(30);
    chk("cont_no_more_update", 64'(upd_rises - r0), 0);
    chk("cont_queue_empty", 64'(exp_q.size()), 0);

    // Abort an in-flight write, then an immediate START that must be ignored
    start_sweep(32'd5000, 32'd1, 3, 2, 0);
    wait_acked("abort_acked");
    tick(2);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("drain_busy", 64'(BUSY), 1);
    chk("drain_update", 64'(UPDATE), 0);
    start_sweep(32'd6000, 32'd1, 3, 2, 0);
    chk("drain_start_ignored", 64'(BUSY), 1);
    wait_idle(100, "drain_idle");
    chk("drain_released_on_updated", 64'(UPDATED), 1);
    push_sweep(32'd7000, 32'd3, 1, 1);
    start_sweep(32'd7000, 32'd3, 1, 0, 0);
    wait_idle(200, "after_drain_idle");
    tick(3);
    chk("after_drain_queue_empty", 64'(exp_q.size()), 0);

    // Timeout: updater never acknowledges
    hang = 1;
    start_sweep(32'd1, 32'd1, 2, 0, 0);
    n = 0;
    while (!UPDATE && n < 10) begin tick(); n++; end
    t0 = cyc;
    n = 0;
    while (!ERROR && n < TO + 100) begin tick(); n++; end
    chk("timeout_cycles", 64'(cyc - t0), 64'(TO));
    chk("timeout_error", 64'(ERROR), 1);
    chk("timeout_update", 64'(UPDATE), 0);
    chk("timeout_busy", 64'(BUSY), 0);
    hang = 0;
    tick(3);

    // Accepted START clears ERROR; then drop INITIED mid-sweep
    exp_q.push_back('{kind: 0, idx: 0, fw: 32'd200});
    s0 = stb_cnt;
    start_sweep(32'd200, 32'd10, 3, 3, 0);
    chk("error_cleared", 64'(ERROR), 0);
    n = 0;
    while (stb_cnt == s0 && n < 200) begin tick(); n++; end
    chk("initdrop_point_seen", 64'(stb_cnt - s0), 1);
    INITIED = 1'b0;
    tick();
    chk("initdrop_error", 64'(ERROR), 1);
    chk("initdrop_busy", 64'(BUSY), 0);
    chk("initdrop_update", 64'(UPDATE), 0);
    INITIED = 1'b1;
    tick(5);
    chk("initdrop_queue_empty", 64'(exp_q.size()), 0);

    // COUNT = 0: DONE only
    r0 = upd_rises; d0 = done_cnt;
    push_sweep(32'd55, 32'd1, 0, 1);
    start_sweep(32'd55, 32'd1, 0, 3, 0);
    chk("count0_busy", 64'(BUSY), 0);
    tick(3);
    chk("count0_done", 64'(done_cnt - d0), 1);
    chk("count0_no_update", 64'(upd_rises - r0), 0);
    chk("count0_queue_empty", 64'(exp_q.size()), 0);

    // DWELL = 0: back-to-back points
    push_sweep(32'd300, 32'd7, 4, 1);
    start_sweep(32'd300, 32'd7, 4, 0, 0);
    wait_idle(500, "dwell0_idle");
    tick(3);
    chk("dwell0_queue_empty", 64'(exp_q.size()), 0);

    // Randomized sweeps with random updater latency
    rand_lat = 1;
    for (int k = 0; k < 6; k++) begin
      logic [31:0] rs, rst_v;
      int rc, rd;
      rs = $urandom; rst_v = $urandom;
      rc = int'($urandom_range(1, 5));
      rd = int'($urandom_range(0, 4));
      push_sweep(rs, rst_v, rc, 1);
      start_sweep(rs, rst_v, rc, rd, 0);
      wait_idle(2000, "rand_idle");
      tick(3);
      chk("rand_queue_empty", 64'(exp_q.size()), 0);
    end
    rand_lat = 0;

    // RESET asserted during WAIT_DONE
    start_sweep(32'd9, 32'd9, 2, 1, 0);
    wait_acked("reset_acked");
    tick(2);
    RESET = 1'b1;
    tick();
    chk("midrst_freqw", 64'(FREQW), 0);
    chk("midrst_update", 64'(UPDATE), 0);
    chk("midrst_busy", 64'(BUSY), 0);
    chk("midrst_idx", 64'(POINT_IDX), 0);
    chk("midrst_stb", 64'(POINT_STB), 0);
    chk("midrst_done", 64'(DONE), 0);
    chk("midrst_error", 64'(ERROR), 0);
    RESET = 1'b0;
    tick(30);
    chk("midrst_queue_empty", 64'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
